// File: rtl/junction_phase_controller_if.sv
// ---------------------------------------------------------------------------
// junction_phase_controller_if
//
// Groups the sensing inputs and lamp-driver outputs of the junction phase
// controller into one bundle.
//
// Signals:
//   congestion   sensing -> controller  main road congested
//   side_req     sensing -> controller  level request per side road
//   phase        controller -> lamps    00 MAIN_GO, 01 MAIN_ATTN,
//                                       10 SIDE_GO, 11 SIDE_ATTN
//   side_grant   controller -> lamps    one-hot served side road, 0 if none
//   phase_start  controller -> lamps    pulse on first cycle of each phase
//
// Modports:
//   master  the sensing side (drives requests, observes phases)
//   slave   the controller
// ---------------------------------------------------------------------------
interface junction_phase_controller_if #(
    parameter int NUM_SIDE = 4
);
    logic                congestion;
    logic [NUM_SIDE-1:0] side_req;
    logic [1:0]          phase;
    logic [NUM_SIDE-1:0] side_grant;
    logic                phase_start;

    modport master (
        output congestion,
        output side_req,
        input  phase,
        input  side_grant,
        input  phase_start
    );

    modport slave (
        input  congestion,
        input  side_req,
        output phase,
        output side_grant,
        output phase_start
    );
endinterface

// File: rtl/junction_phase_controller.sv
// ---------------------------------------------------------------------------
// junction_phase_controller
//
// Cycle-counted traffic-phase controller for a main road crossed by NUM_SIDE
// side roads. Main road stays GO until a side road requests; congestion on
// the main road extends its GO time up to T_MAIN_MAX, after which a pending
// request forces the change. Side roads are served one at a time by
// round-robin arbitration.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   bus          slave modport of junction_phase_controller_if
//                (congestion, side_req in; phase, side_grant, phase_start out)
//   cycle_count  out  [15:0] completed side-service cycles, saturating
//                (present only when JUNCTION_CYCLE_COUNT_EN is defined)
//
// Optional feature macro: JUNCTION_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module junction_phase_controller #(
    parameter int NUM_SIDE   = 4,
    parameter int T_MAIN_GO  = 20,
    parameter int T_MAIN_MAX = 60,
    parameter int T_SIDE_GO  = 10,
    parameter int T_ATTN     = 3
) (
    input  logic                              clock,
    input  logic                              reset_n,
    junction_phase_controller_if.slave        bus
`ifdef JUNCTION_CYCLE_COUNT_EN
    ,
    output logic [15:0]                       cycle_count
`endif
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int PTR_W  = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;
    localparam int EL_W   = $clog2(T_MAIN_MAX + 1);
    localparam int T_LONG = (T_SIDE_GO > T_ATTN) ? T_SIDE_GO : T_ATTN;
    localparam int TMR_W  = $clog2(T_LONG) + 1;

    localparam logic [EL_W-1:0]  EL_ONE      = EL_W'(1);
    localparam logic [EL_W-1:0]  EL_MAIN_GO  = EL_W'(T_MAIN_GO);
    localparam logic [EL_W-1:0]  EL_MAIN_MAX = EL_W'(T_MAIN_MAX);
    localparam logic [TMR_W-1:0] TMR_ATTN_LD = TMR_W'(T_ATTN - 1);
    localparam logic [TMR_W-1:0] TMR_SIDE_LD = TMR_W'(T_SIDE_GO - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [PTR_W:0]   N_EXT       = (PTR_W + 1)'(NUM_SIDE);
    localparam logic [PTR_W:0]   PTR_ONE     = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        PH_MAIN_GO   = 2'b00,
        PH_MAIN_ATTN = 2'b01,
        PH_SIDE_GO   = 2'b10,
        PH_SIDE_ATTN = 2'b11
    } phase_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    phase_e              state_q, state_d;
    logic [EL_W-1:0]     elapsed_q, elapsed_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                forced_q, forced_d;
    logic [NUM_SIDE-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                phase_start_q, phase_start_d;
`ifdef JUNCTION_CYCLE_COUNT_EN
    logic [15:0]         count_q, count_d;
`endif

    // -----------------------------------------------------------------------
    // Decision terms
    // -----------------------------------------------------------------------
    logic any_req;
    logic elapsed_at_min;
    logic elapsed_at_max;
    logic main_exit;
    logic timer_done;
    logic side_go_ok;

    assign any_req        = |bus.side_req;
    assign elapsed_at_min = (elapsed_q >= EL_MAIN_GO);
    assign elapsed_at_max = (elapsed_q == EL_MAIN_MAX);
    // Congestion holds main GO until the starvation limit is reached.
    assign main_exit      = elapsed_at_min && any_req &&
                            (!bus.congestion || elapsed_at_max);
    assign timer_done     = (timer_q == '0);
    // A forced exit serves the side road even if congestion persists;
    // otherwise fresh congestion or a vanished request means clearance only.
    assign side_go_ok     = any_req && (!bus.congestion || forced_q);

    // -----------------------------------------------------------------------
    // Round-robin arbitration
    // Rotate the requests so the pointer position sits at bit 0, take the
    // lowest set bit, then rotate the offset back into an absolute index.
    // -----------------------------------------------------------------------
    logic [2*NUM_SIDE-1:0] req_dbl;
    logic [NUM_SIDE-1:0]   req_rot;
    logic [PTR_W-1:0]      arb_off;
    logic [PTR_W:0]        arb_sum;
    logic [PTR_W-1:0]      arb_idx;
    logic [PTR_W:0]        arb_inc;
    logic [PTR_W-1:0]      arb_ptr_next;
    logic [NUM_SIDE-1:0]   arb_onehot;

    assign req_dbl = {bus.side_req, bus.side_req};
    assign req_rot = NUM_SIDE'(req_dbl >> rr_ptr_q);

    always_comb begin
        arb_off = '0;
        for (int k = NUM_SIDE - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_off = PTR_W'(k);
            end
        end
    end

    assign arb_sum      = {1'b0, rr_ptr_q} + {1'b0, arb_off};
    assign arb_idx      = (arb_sum >= N_EXT) ? PTR_W'(arb_sum - N_EXT)
                                             : PTR_W'(arb_sum);
    assign arb_inc      = {1'b0, arb_idx} + PTR_ONE;
    assign arb_ptr_next = (arb_inc == N_EXT) ? '0 : PTR_W'(arb_inc);

    for (genvar gi = 0; gi < NUM_SIDE; gi++) begin : g_onehot
        assign arb_onehot[gi] = (arb_idx == PTR_W'(gi));
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PH_MAIN_GO;
            elapsed_q     <= EL_ONE;
            timer_q       <= '0;
            forced_q      <= 1'b0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            phase_start_q <= 1'b0;
`ifdef JUNCTION_CYCLE_COUNT_EN
            count_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            timer_q       <= timer_d;
            forced_q      <= forced_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            phase_start_q <= phase_start_d;
`ifdef JUNCTION_CYCLE_COUNT_EN
            count_q       <= count_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_MAIN_GO: begin
                if (main_exit) begin
                    state_d = PH_MAIN_ATTN;
                end
            end
            PH_MAIN_ATTN: begin
                if (timer_done) begin
                    state_d = side_go_ok ? PH_SIDE_GO : PH_SIDE_ATTN;
                end
            end
            PH_SIDE_GO: begin
                if (timer_done) begin
                    state_d = PH_SIDE_ATTN;
                end
            end
            default: begin  // PH_SIDE_ATTN
                if (timer_done) begin
                    state_d = PH_MAIN_GO;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        elapsed_d     = elapsed_q;
        timer_d       = timer_q;
        forced_d      = forced_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        phase_start_d = (state_d != state_q);
        case (state_q)
            PH_MAIN_GO: begin
                if (main_exit) begin
                    timer_d  = TMR_ATTN_LD;
                    forced_d = elapsed_at_max;
                end else if (!elapsed_at_max) begin
                    elapsed_d = elapsed_q + EL_ONE;
                end
            end
            PH_MAIN_ATTN: begin
                if (timer_done) begin
                    if (side_go_ok) begin
                        grant_d  = arb_onehot;
                        rr_ptr_d = arb_ptr_next;
                        timer_d  = TMR_SIDE_LD;
                    end else begin
                        // Clearance: no road served, pointer left alone.
                        grant_d  = '0;
                        timer_d  = TMR_ATTN_LD;
                    end
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            PH_SIDE_GO: begin
                if (timer_done) begin
                    timer_d = TMR_ATTN_LD;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin  // PH_SIDE_ATTN
                if (timer_done) begin
                    grant_d   = '0;
                    forced_d  = 1'b0;
                    elapsed_d = EL_ONE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
        endcase
    end

`ifdef JUNCTION_CYCLE_COUNT_EN
    always_comb begin
        count_d = count_q;
        if ((state_q == PH_SIDE_ATTN) && timer_done && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    assign cycle_count = count_q;
`endif

    assign bus.phase       = state_q;
    assign bus.side_grant  = grant_q;
    assign bus.phase_start = phase_start_q;

endmodule
